// File: rtl/count_period_monitor.sv
// count_period_monitor: watches the counter chain output, times each change,
// checks +1 steps and flags stalls. Min/max tracking: COUNT_PERIOD_MINMAX_EN.
module count_period_monitor #(
   parameter int COUNT_WIDTH    = 16,
   parameter int PERIOD_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic [COUNT_WIDTH-1:0]  count_in,
   output logic                    period_valid,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0]  step_count,
   output logic                    seq_error,
   output logic                    stall
`ifdef COUNT_PERIOD_MINMAX_EN
   ,
   output logic [PERIOD_WIDTH-1:0] min_period,
   output logic [PERIOD_WIDTH-1:0] max_period
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      STALLED = 2'd2
   } state_t;

   localparam logic [PERIOD_WIDTH-1:0] TIMEOUT =
      PERIOD_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] STEP_MAX = '1;

   state_t                  state_q;
   state_t                  state_d;
   logic                    primed_q;
   logic [COUNT_WIDTH-1:0]  count_q;
   logic [PERIOD_WIDTH-1:0] timer_q;
   logic [PERIOD_WIDTH-1:0] timer_d;
   logic [PERIOD_WIDTH-1:0] timer_inc;
   logic [PERIOD_WIDTH-1:0] period_d;
   logic                    valid_d;
   logic [COUNT_WIDTH-1:0]  step_d;
   logic                    err_d;
   logic                    stall_d;
   logic                    change;
   logic                    seq_ok;
`ifdef COUNT_PERIOD_MINMAX_EN
   logic [PERIOD_WIDTH-1:0] min_d;
   logic [PERIOD_WIDTH-1:0] max_d;
`endif

   assign change    = primed_q & (count_in != count_q);
   assign seq_ok    = (count_in == count_q + COUNT_WIDTH'(1));
   assign timer_inc = timer_q + PERIOD_WIDTH'(1);

   // Reference sample of the count; any edge after reset leaves us primed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q  <= '0;
         primed_q <= 1'b0;
      end else begin
         count_q  <= count_in;
         primed_q <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and next values of every measured output.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      period_d = period;
      valid_d  = 1'b0;
      step_d   = step_count;
      err_d    = seq_error;
      stall_d  = stall;
      if (change) begin
         if (step_count != STEP_MAX) step_d = step_count + COUNT_WIDTH'(1);
         if (!seq_ok) err_d = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (change) state_d = MEASURE;
         end
         MEASURE: begin
            if (change) begin
               period_d = timer_inc;
               valid_d  = 1'b1;
               timer_d  = '0;
            end else if (timer_inc == TIMEOUT) begin
               state_d = STALLED;
               stall_d = 1'b1;
            end else begin
               timer_d = timer_inc;
            end
         end
         STALLED: begin
            if (change) begin
               state_d = MEASURE;
               stall_d = 1'b0;
               timer_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef COUNT_PERIOD_MINMAX_EN
      min_d = min_period;
      max_d = max_period;
      if (valid_d && period_d < min_period) min_d = period_d;
      if (valid_d && period_d > max_period) max_d = period_d;
`endif
      // A soft clear wins over any change seen on the same edge.
      if (clear) begin
         state_d  = IDLE;
         timer_d  = '0;
         period_d = '0;
         valid_d  = 1'b0;
         step_d   = '0;
         err_d    = 1'b0;
         stall_d  = 1'b0;
`ifdef COUNT_PERIOD_MINMAX_EN
         min_d    = '1;
         max_d    = '0;
`endif
      end
   end

   // Measurement registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_q      <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         step_count   <= '0;
         seq_error    <= 1'b0;
         stall        <= 1'b0;
      end else begin
         timer_q      <= timer_d;
         period       <= period_d;
         period_valid <= valid_d;
         step_count   <= step_d;
         seq_error    <= err_d;
         stall        <= stall_d;
      end
   end

`ifdef COUNT_PERIOD_MINMAX_EN
   // Running extremes of the reported periods.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         min_period <= '1;
         max_period <= '0;
      end else begin
         min_period <= min_d;
         max_period <= max_d;
      end
   end
`endif

endmodule

// File: tb/tb_count_period_monitor.sv
// tb_count_period_monitor: random and directed stimulus against a
// gap-based reference model; pulses checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_count_period_monitor;

   localparam int CW = 16;
   localparam int PW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          clear = 1'b0;
   logic [CW-1:0] count_in = '0;
   logic          period_valid;
   logic [PW-1:0] period;
   logic [CW-1:0] step_count;
   logic          seq_error;
   logic          stall;
`ifdef COUNT_PERIOD_MINMAX_EN
   logic [PW-1:0] min_period;
   logic [PW-1:0] max_period;
`endif

   always #5 clk = ~clk;

   count_period_monitor #(
      .COUNT_WIDTH(CW),
      .PERIOD_WIDTH(PW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .count_in(count_in),
      .period_valid(period_valid),
      .period(period),
      .step_count(step_count),
      .seq_error(seq_error),
      .stall(stall)
`ifdef COUNT_PERIOD_MINMAX_EN
      ,
      .min_period(min_period),
      .max_period(max_period)
`endif
   );

   int total = 0;
   int bad = 0;

   bit            m_primed;
   bit            m_ref;
   logic [CW-1:0] m_last;
   longint        m_n = 0;
   longint        m_edge;
   logic [CW-1:0] m_steps;
   bit            m_err;
   logic [PW-1:0] m_period;
   bit            m_stall;
   logic [PW-1:0] m_min;
   logic [PW-1:0] m_max;
   logic [PW-1:0] pq[$];
   bit            chk_en = 1'b0;
   logic [CW-1:0] cur;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_primed = 1'b0;
      m_ref    = 1'b0;
      m_last   = '0;
      m_edge   = 0;
      m_steps  = '0;
      m_err    = 1'b0;
      m_period = '0;
      m_stall  = 1'b0;
      m_min    = '1;
      m_max    = '0;
      pq.delete();
   endtask

   // One clock edge of the reference: changes are timed as edge distances.
   task automatic model_edge(bit c, logic [CW-1:0] v);
      longint gap;
      m_n++;
      if (c) begin
         model_reset();
         m_primed = 1'b1;
         m_last   = v;
         return;
      end
      gap = m_n - m_edge;
      if (m_primed && v != m_last) begin
         if (m_steps != 16'hFFFF) m_steps++;
         if (v != CW'(m_last + 1)) m_err = 1'b1;
         if (m_ref && gap <= TO) begin
            m_period = PW'(gap);
            pq.push_back(m_period);
            if (m_period < m_min) m_min = m_period;
            if (m_period > m_max) m_max = m_period;
         end
         m_ref   = 1'b1;
         m_edge  = m_n;
         m_stall = 1'b0;
      end else if (m_ref && gap >= TO) begin
         m_stall = 1'b1;
      end
      m_primed = 1'b1;
      m_last   = v;
   endtask

   task automatic drive(bit c, logic [CW-1:0] v);
      clear    = c;
      count_in = v;
      @(posedge clk);
      model_edge(c, v);
      #1;
      clear = 1'b0;
   endtask

   task automatic hold(int n);
      for (int i = 0; i < n; i++) drive(1'b0, count_in);
   endtask

   task automatic check_reset_vals(string tag);
      check({tag, "_valid"}, period_valid, 0);
      check({tag, "_period"}, period, 0);
      check({tag, "_steps"}, step_count, 0);
      check({tag, "_err"}, seq_error, 0);
      check({tag, "_stall"}, stall, 0);
`ifdef COUNT_PERIOD_MINMAX_EN
      check({tag, "_min"}, min_period, 64'(32'hFFFF_FFFF));
      check({tag, "_max"}, max_period, 0);
`endif
   endtask

   // Monitor: pops an expected period on each pulse, checks held status.
   always @(negedge clk) begin
      if (chk_en && reset) begin
         if (period_valid) begin
            if (pq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_pulse got=1 want=0");
            end else begin
               check("pulse_period", period, pq.pop_front());
            end
         end else if (pq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL missing_pulse got=0 want=1 (period %0d)",
                     pq[0]);
            pq.delete();
         end
         check("period_hold", period, m_period);
         check("step_count", step_count, m_steps);
         check("seq_error", seq_error, m_err);
         check("stall", stall, m_stall);
`ifdef COUNT_PERIOD_MINMAX_EN
         check("min_period", min_period, m_min);
         check("max_period", max_period, m_max);
`endif
      end
   end

   initial begin
      model_reset();
      #12;
      check_reset_vals("reset");
      @(negedge clk);
      reset  = 1'b1;
      chk_en = 1'b1;

      // Count every cycle: first change no pulse, then period 1.
      for (int i = 0; i < 20; i++) drive(1'b0, CW'(i));

      // Stall after TO idle edges, resume without pulse, then period 3.
      hold(10);
      drive(1'b0, 16'd20);
      hold(2);
      drive(1'b0, 16'd21);
      hold(1);

      // Legal wrap all-ones to zero.
      drive(1'b1, 16'hFFFE);
      drive(1'b0, 16'hFFFF);
      drive(1'b0, 16'h0000);
      drive(1'b0, 16'h0001);

      // Clear on the same edge as a change discards the change.
      drive(1'b1, 16'd7);
      hold(2);

      // Jump 5 -> 9 is sticky until clear.
      drive(1'b1, 16'd5);
      drive(1'b0, 16'd9);
      drive(1'b0, 16'd10);
      drive(1'b0, 16'd11);
      drive(1'b1, 16'd11);
      hold(1);

      // Periods 4, 2, 7.
      drive(1'b0, 16'd12);
      hold(3);
      drive(1'b0, 16'd13);
      hold(1);
      drive(1'b0, 16'd14);
      hold(6);
      drive(1'b0, 16'd15);
      hold(1);

      // Random gaps around the timeout, occasional jumps and clears.
      drive(1'b1, 16'd0);
      cur = 16'd0;
      for (int it = 0; it < 400; it++) begin
         int r;
         int gap;
         r   = $urandom_range(0, 29);
         gap = $urandom_range(1, 11);
         hold(gap - 1);
         if (r == 0) begin
            cur = CW'($urandom);
            drive(1'b1, cur);
         end else begin
            if (r < 3) cur = CW'($urandom);
            else       cur = cur + 16'd1;
            drive(1'b0, cur);
         end
      end

      // Saturation of step_count.
      drive(1'b1, 16'd0);
      for (int i = 1; i <= 65540; i++) drive(1'b0, CW'(i));

      // Asynchronous reset in the middle of a measurement.
      drive(1'b1, 16'd0);
      drive(1'b0, 16'd1);
      hold(1);
      drive(1'b0, 16'd2);
      hold(2);
      #2;
      reset = 1'b0;
      #1;
      check_reset_vals("async");
      @(negedge clk);
      model_reset();
      reset = 1'b1;
      drive(1'b0, 16'd40);
      drive(1'b0, 16'd41);
      drive(1'b0, 16'd42);
      hold(2);

      chk_en = 1'b0;
      check("queue_empty", pq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
